// File: rtl/pc_addr_ir_pkg.sv
// Shared constants, types and the immediate sign-extender for the pc_addr_ir datapath slice.
package pc_addr_ir_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned IMM_W    = 12;
  localparam int unsigned RF_DEPTH = 2 ** ID_W;

  // Register-ID field deliberately overlaps the upper immediate bits.
  localparam int unsigned ID_MSB  = 11;
  localparam int unsigned ID_LSB  = 8;
  localparam int unsigned IMM_MSB = 11;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ID_W-1:0]   reg_id_t;

  function automatic word_t sign_ext12(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/pc_addr_ir_if.sv
// Control/data bundle between fetch, the pc_addr_ir slice and the ALU/memory stage.
interface pc_addr_ir_if;
  import pc_addr_ir_pkg::*;

  logic  enable;
  word_t instruction;
  logic  set_id;
  logic  write;
  word_t data_in;
  logic  cr_write;
  word_t cr_data_in;
  word_t read_data_a;
  word_t cool_data;
  word_t seout;

  modport master (
    output enable, instruction, set_id, write, data_in, cr_write, cr_data_in,
    input  read_data_a, cool_data, seout
  );

  modport slave (
    input  enable, instruction, set_id, write, data_in, cr_write, cr_data_in,
    output read_data_a, cool_data, seout
  );

endinterface

// File: rtl/reg_file16.sv
// 16-entry register file: asynchronous read, synchronous write, asynchronous active-low clear.
module reg_file16
  import pc_addr_ir_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we_i,
  input  reg_id_t addr_i,
  input  word_t   wdata_i,
  output word_t   rdata_o
);

  word_t mem_q [RF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // No write-through bypass: a written value appears after the write edge.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pc_addr_ir.sv
// Front-end datapath slice: IR, immediate sign-extender, ID-addressed register file and CR.
// Define CR_BYPASS_EN to forward a pending CR load combinationally onto cool_data.
module pc_addr_ir
  import pc_addr_ir_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  pc_addr_ir_if.slave bus
);

  word_t   ir_q;
  word_t   cr_q;
  reg_id_t id_q;
  word_t   rf_rdata;

  // ID samples the pre-edge IR, so a freshly loaded instruction needs set_id a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
      id_q <= '0;
      cr_q <= '0;
    end else begin
      if (bus.enable) begin
        ir_q <= bus.instruction;
      end
      if (bus.set_id) begin
        id_q <= ir_q[ID_MSB:ID_LSB];
      end
      if (bus.cr_write) begin
        cr_q <= bus.cr_data_in;
      end
    end
  end

  reg_file16 u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.write),
    .addr_i  (id_q),
    .wdata_i (bus.data_in),
    .rdata_o (rf_rdata)
  );

  assign bus.read_data_a = rf_rdata;
  assign bus.seout       = sign_ext12(ir_q[IMM_MSB:0]);

`ifdef CR_BYPASS_EN
  assign bus.cool_data = bus.cr_write ? bus.cr_data_in : cr_q;
`else
  assign bus.cool_data = cr_q;
`endif

  // Opcode bits are consumed downstream, not here.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir_q[DATA_W-1:IMM_W];

endmodule

// File: tb/tb_pc_addr_ir.sv
// Directed self-checking bench for pc_addr_ir; expectations are queued and drained at each sample.
module tb_pc_addr_ir;

  logic clk;
  logic rst_n;

  pc_addr_ir_if bus ();

  pc_addr_ir dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SelRd   = 0;
  localparam int SelCool = 1;
  localparam int SelSe   = 2;

  typedef struct {
    int          sel;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  task automatic expect_val(input int sel, input logic [15:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SelRd:   obs = bus.read_data_a;
        SelCool: obs = bus.cool_data;
        default: obs = bus.seout;
      endcase
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.enable      = 1'b0;
    bus.instruction = '0;
    bus.set_id      = 1'b0;
    bus.write       = 1'b0;
    bus.data_in     = '0;
    bus.cr_write    = 1'b0;
    bus.cr_data_in  = '0;
    #12 rst_n = 1'b1;

    expect_val(SelRd,   16'h0000, "reset_rd");
    expect_val(SelCool, 16'h0000, "reset_cool");
    expect_val(SelSe,   16'h0000, "reset_se");
    check_all();

    // Build non-zero state, then clear it with a mid-cycle reset pulse.
    bus.enable = 1'b1; bus.instruction = 16'h0F00;
    bus.cr_write = 1'b1; bus.cr_data_in = 16'h1111;
    step();
    bus.enable = 1'b0; bus.cr_write = 1'b0; bus.set_id = 1'b1;
    step();
    bus.set_id = 1'b0; bus.write = 1'b1; bus.data_in = 16'h2222;
    step();
    bus.write = 1'b0;
    expect_val(SelRd,   16'h2222, "pre_rst_rd");
    expect_val(SelCool, 16'h1111, "pre_rst_cool");
    expect_val(SelSe,   16'hFF00, "pre_rst_se");
    check_all();
    #3 rst_n = 1'b0;
    #1;
    expect_val(SelRd,   16'h0000, "async_rst_rd");
    expect_val(SelCool, 16'h0000, "async_rst_cool");
    expect_val(SelSe,   16'h0000, "async_rst_se");
    check_all();
    #2 rst_n = 1'b1;

    // IR load and sign extension.
    bus.enable = 1'b1; bus.instruction = 16'h3800;
    step();
    expect_val(SelSe, 16'hF800, "se_neg");
    check_all();
    bus.instruction = 16'h37FF;
    step();
    expect_val(SelSe, 16'h07FF, "se_pos");
    check_all();
    bus.enable = 1'b0; bus.instruction = 16'h0123;
    step();
    expect_val(SelSe, 16'h07FF, "ir_hold");
    check_all();

    // Register file via latched ID.
    bus.enable = 1'b1; bus.instruction = 16'h0500;
    step();
    bus.enable = 1'b0; bus.set_id = 1'b1;
    step();
    bus.set_id = 1'b0;
    expect_val(SelRd, 16'h0000, "rf5_init");
    check_all();
    bus.write = 1'b1; bus.data_in = 16'hBEEF;
    step();
    bus.write = 1'b0;
    expect_val(SelRd, 16'hBEEF, "rf5_write");
    check_all();
    bus.enable = 1'b1; bus.instruction = 16'h0600;
    step();
    bus.enable = 1'b0; bus.set_id = 1'b1;
    step();
    bus.set_id = 1'b0;
    expect_val(SelRd, 16'h0000, "rf6_empty");
    check_all();
    bus.enable = 1'b1; bus.instruction = 16'h0500;
    step();
    bus.enable = 1'b0; bus.set_id = 1'b1;
    step();
    bus.set_id = 1'b0;
    expect_val(SelRd, 16'hBEEF, "rf5_retain");
    check_all();

    // set_id and write together: write targets the old ID.
    bus.enable = 1'b1; bus.instruction = 16'h0900;
    step();
    bus.enable = 1'b0; bus.set_id = 1'b1; bus.write = 1'b1; bus.data_in = 16'h1234;
    step();
    bus.set_id = 1'b0; bus.write = 1'b0;
    expect_val(SelRd, 16'h0000, "rf9_untouched");
    check_all();
    bus.enable = 1'b1; bus.instruction = 16'h0500;
    step();
    bus.enable = 1'b0; bus.set_id = 1'b1;
    step();
    bus.set_id = 1'b0;
    expect_val(SelRd, 16'h1234, "rf5_old_id_write");
    check_all();

    // CR load and hold.
    bus.cr_write = 1'b1; bus.cr_data_in = 16'hA5A5;
    #1;
`ifdef CR_BYPASS_EN
    expect_val(SelCool, 16'hA5A5, "cr_pre_edge");
`else
    expect_val(SelCool, 16'h0000, "cr_pre_edge");
`endif
    check_all();
    step();
    bus.cr_write = 1'b0; bus.cr_data_in = 16'h5A5A;
    expect_val(SelCool, 16'hA5A5, "cr_load");
    check_all();
    step();
    expect_val(SelCool, 16'hA5A5, "cr_hold");
    check_all();

    // Every enable at once: IR=new, ID=old IR (5), RF[old ID]=data, CR=data.
    bus.enable = 1'b1; bus.instruction = 16'h0A77;
    bus.set_id = 1'b1;
    bus.write = 1'b1; bus.data_in = 16'h4321;
    bus.cr_write = 1'b1; bus.cr_data_in = 16'h0F0F;
    step();
    bus.enable = 1'b0; bus.set_id = 1'b0; bus.write = 1'b0; bus.cr_write = 1'b0;
    expect_val(SelSe,   16'hFA77, "all_se");
    expect_val(SelRd,   16'h4321, "all_rd_old_id");
    expect_val(SelCool, 16'h0F0F, "all_cool");
    check_all();
    bus.set_id = 1'b1;
    step();
    bus.set_id = 1'b0;
    expect_val(SelRd, 16'h0000, "all_rfA_untouched");
    expect_val(SelSe, 16'hFA77, "all_se_hold");
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
